// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// reset PC default and word-alignment helpers.
package instr_fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC select: redirect beats sequential
// advance, otherwise the PC holds.
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        advance,
  input  logic [31:0] seq_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_next
);

  logic [31:0] pc_r;

  // Next-PC select; redirect wins over the sequential increment.
  always_comb begin
    pc_next = pc_r;
    if (redirect) begin
      pc_next = align_word(target);
    end else if (advance) begin
      pc_next = seq_pc;
    end else begin
      pc_next = pc_r;
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: issues word reads, holds the returned word for
// control, and drops wrong-path responses after a redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      pc_plus4,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             addr_err,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_t     state_r, state_next;
  logic             flush_r, flush_next;
  logic             mem_req_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      instr_r;
  logic [31:0]      instr_pc_r;
  logic             addr_err_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      pc_s;
  logic [31:0]      pc_next_s;
  logic             mem_fire_s;
  logic             accept_s;
  logic             capture_s;

  assign mem_fire_s = mem_req_r & mem_ready;
  assign accept_s   = (state_r == HOLD) & instr_ready;
  assign capture_s  = (state_r == FETCH) & mem_fire_s & ~flush_r & ~redirect_valid;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .redirect(redirect_valid),
    .target  (redirect_target),
    .advance (accept_s),
    .seq_pc  (pc_plus4),
    .pc      (pc_s),
    .pc_next (pc_next_s)
  );

  // Next state and wrong-path flush tracking.
  always_comb begin
    state_next = state_r;
    flush_next = flush_r;
    case (state_r)
      FETCH: begin
        if (mem_fire_s) begin
          flush_next = 1'b0;
          if (capture_s) state_next = HOLD;
          else           state_next = FETCH;
        end else if (redirect_valid && mem_req_r) begin
          flush_next = 1'b1;
        end else begin
          flush_next = flush_r;
        end
      end
      HOLD: begin
        if (accept_s || redirect_valid) state_next = FETCH;
        else                            state_next = HOLD;
      end
      default: begin
        state_next = FETCH;
        flush_next = 1'b0;
      end
    endcase
  end

  // Registered state, request, instruction register and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= FETCH;
      flush_r    <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= RESET_PC;
      instr_r    <= 32'h0000_0000;
      instr_pc_r <= 32'h0000_0000;
      addr_err_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_next;
      flush_r   <= flush_next;
      mem_req_r <= (state_next == FETCH);
      // An in-flight request keeps its address until the memory answers.
      if (!mem_req_r || mem_ready) mem_addr_r <= pc_next_s;
      else                         mem_addr_r <= mem_addr_r;
      if (capture_s) begin
        instr_r    <= mem_rdata;
        instr_pc_r <= pc_s;
      end else begin
        instr_r    <= instr_r;
        instr_pc_r <= instr_pc_r;
      end
      if (redirect_valid && (redirect_target[1:0] != 2'b00)) addr_err_r <= 1'b1;
      else                                                   addr_err_r <= addr_err_r;
      if (accept_s && (cnt_r != {CNT_W{1'b1}})) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                      cnt_r <= cnt_r;
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr_valid = (state_r == HOLD);
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign pc_plus4    = instr_pc_r + 32'd4;
  assign addr_err    = addr_err_r;
  assign instr_count = cnt_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level model
// of the fetch stage, plus directed literal checks.
module tb_instr_fetch_unit;

  localparam int CW     = 4;
  localparam int CNTMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [31:0]   pc_plus4;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic          addr_err;
  logic [CW-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  // model state: pending request, architectural pc, held instruction
  logic        m_req, m_flush, m_valid, m_err;
  logic [31:0] m_addr, m_pc, m_instr, m_ipc;
  int          m_cnt;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .addr_err       (addr_err),
    .instr_count    (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'd7 + 32'd3;
    return t[7:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mbyte(a), mbyte(a + 32'd1), mbyte(a + 32'd2), mbyte(a + 32'd3)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_flush = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_addr = 32'h0; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_cnt = 0;
  endtask

  // compare process: DUT outputs vs model, every falling edge
  always @(negedge clk) begin
    check("mem_req", {31'b0, mem_req}, {31'b0, m_req});
    if (m_req) check("mem_addr", mem_addr, m_addr);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
      check("pc_plus4", pc_plus4, m_ipc + 32'd4);
    end
    check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
    check("instr_count", {28'b0, instr_count}, m_cnt);
  end

  // One cycle: drive inputs, predict next outputs, advance to next negedge+1.
  task automatic step(input logic rv, input logic [31:0] rt, input logic mr, input logic ir);
    logic fire, acc;
    logic        n_req, n_flush, n_valid, n_err;
    logic [31:0] n_addr, n_pc, n_instr, n_ipc;
    int          n_cnt;
    redirect_valid  = rv;
    redirect_target = rt;
    instr_ready     = ir;
    mem_ready       = mr & m_req;
    mem_rdata       = m_req ? word_at(m_addr) : $urandom;
    fire = mr & m_req;
    acc  = m_valid & ir;
    n_req = m_req; n_flush = m_flush; n_valid = m_valid; n_err = m_err;
    n_addr = m_addr; n_instr = m_instr; n_ipc = m_ipc; n_cnt = m_cnt;
    if (acc && m_cnt < CNTMAX) n_cnt = m_cnt + 1;
    if (rv && rt[1:0] != 2'b00) n_err = 1'b1;
    n_pc = rv ? (rt & 32'hFFFF_FFFC) : (acc ? m_ipc + 32'd4 : m_pc);
    if (m_valid) begin
      if (acc || rv) n_valid = 1'b0;
    end else if (fire) begin
      n_flush = 1'b0;
      if (!m_flush && !rv) begin
        n_valid = 1'b1;
        n_instr = word_at(m_addr);
        n_ipc   = m_pc;
      end
    end else if (rv && m_req) begin
      n_flush = 1'b1;
    end
    n_req = !n_valid;
    if (!m_req || fire) n_addr = n_pc;
    @(posedge clk);
    #1;
    m_req = n_req; m_flush = n_flush; m_valid = n_valid; m_err = n_err;
    m_addr = n_addr; m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc; m_cnt = n_cnt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic        rv, mr, ir;
    logic [31:0] rt;
    int          guard;
    model_reset();
    reset = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_instr", instr, 32'h0);
    check("reset_instr_pc", instr_pc, 32'h0);
    #1 reset = 1'b1;

    // zero-wait sequential fetch of four words
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("first_req_addr", mem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      check("seq_instr_pc", instr_pc, 32'(k * 4));
      if (k == 0) check("big_endian_word0", instr, 32'h030A_1118);
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    check("count_after_4", {28'b0, instr_count}, 32'd4);

    // redirect while a request is outstanding: response dropped
    step(1'b1, 32'h0000_002C, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("flushed_not_valid", {31'b0, instr_valid}, 32'd0);
    check("redirect_addr", mem_addr, 32'h0000_002C);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("redirect_instr_pc", instr_pc, 32'h0000_002C);
    // hold for five cycles, then accept together with a misaligned redirect
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0031, 1'b0, 1'b1);
    check("misaligned_err", {31'b0, addr_err}, 32'd1);
    check("aligned_target", mem_addr, 32'h0000_0030);
    check("count_with_accept", {28'b0, instr_count}, 32'd5);
    // wrap of pc_plus4 at the top of the address space
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_next_addr", mem_addr, 32'h0);

    // randomized traffic with a reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1200) begin
        guard = 0;
        while (!m_req && guard < 20) begin
          step(1'b0, 32'h0, 1'b0, 1'b1);
          guard++;
        end
        check("req_before_reset", {31'b0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_count", {28'b0, instr_count}, 32'd0);
        model_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("post_reset_addr", mem_addr, 32'h0);
      end
      rv = ($urandom_range(0, 9) == 0);
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFFC;
      mr = ($urandom_range(0, 2) != 0);
      ir = ($urandom_range(0, 3) != 0);
      step(rv, rt, mr, ir);
    end
    check("count_saturated", {28'b0, instr_count}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multicycle fetch stage between the program counter and the main control unit.
- Owns the PC and issues word reads to instruction memory over a req/ready handshake.
- Latches the returned word into an instruction register and presents it to control over a valid/ready handshake.
- Applies branch/jump redirects from downstream and discards wrong-path fetches.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
CNT_W, 16, width of the saturating retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
mem_req  out  1  instruction memory read request.
mem_addr  out  32  byte address of the word being fetched.
mem_rdata  in  32  instruction word, big-endian byte order; valid when mem_ready=1.
mem_ready  in  1  memory completes the read this cycle.
instr_valid  out  1  instr/instr_pc/pc_plus4 hold a valid instruction.
instr_ready  in  1  control consumes the instruction this cycle.
instr  out  32  instruction register contents.
instr_pc  out  32  address the instruction was fetched from.
pc_plus4  out  32  instr_pc + 4.
redirect_valid  in  1  one-cycle pulse: the next fetch goes to redirect_target.
redirect_target  in  32  branch/jump destination.
addr_err  out  1  sticky: a redirect target was misaligned.
instr_count  out  CNT_W  accepted instructions, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=FETCH; pc=RESET_PC.
  - mem_req=0, instr_valid=0, instr=0, instr_pc=0, addr_err=0, instr_count=0, flush=0.
  - On the first clk after deassertion, mem_req asserts.
- States: FETCH, HOLD.
- FETCH:
  - mem_req=1, mem_addr=pc; both held stable until mem_ready=1.
  - On mem_ready=1 with flush=0: instr<=mem_rdata, instr_pc<=pc, go to HOLD.
  - On mem_ready=1 with flush=1: discard mem_rdata, flush<=0, stay in FETCH. mem_req stays 1 and mem_addr changes to the new pc in the next cycle.
- HOLD:
  - mem_req=0, instr_valid=1.
  - instr/instr_pc are stable until the instruction is accepted (instr_valid & instr_ready) or flushed.
  - On accept: pc<=instr_pc+4, instr_count++ (saturating at all-ones), go to FETCH.
- Latency: the instruction is valid in the cycle after mem_ready. Minimum fetch-to-fetch period is 2 cycles with zero-wait memory and instr_ready held at 1.
- Redirect:
  - Target alignment: pc<=redirect_target & ~32'h3. If redirect_target[1:0]!=0, addr_err<=1, cleared only by reset.
  - In FETCH, no mem_ready in the same cycle: pc<=target, flush<=1. The in-flight request keeps its old address until mem_ready, and that response is dropped.
  - In FETCH, mem_ready in the same cycle: response dropped, pc<=target, stay in FETCH, flush stays 0.
  - In HOLD without accept: instr_valid drops next cycle, instruction discarded, not counted; pc<=target, go to FETCH.
  - In HOLD with accept in the same cycle: instruction counted; pc<=target, not instr_pc+4.
  - Redirect always wins over sequential PC increment.
- pc_plus4 = instr_pc + 4, combinational, modulo 2^32. 32'hFFFFFFFC wraps to 0 with no error.
- Reset mid-transaction: the outstanding memory request is abandoned with no handshake. The memory must tolerate mem_req dropping without mem_ready.
- instr_ready while instr_valid=0 is ignored.

Decomposition:
- Shared package: state encoding (FETCH=1'b0, HOLD=1'b1), RESET_PC default, and the 32'hFFFFFFFC word-alignment mask constant.
- One sub-module, fetch_pc_reg: the PC register with async active-low reset and next-PC select (sequential / redirect / hold).

Test Plan:
- Zero-wait memory, instr_ready=1, mem holds 4 words from 0 -> instr_pc sequence 0,4,8,12; instr_valid every other cycle; instr_count=4.
- mem_ready delayed 3 cycles -> mem_addr stable 4 cycles; instr equals the word {Mem[0],Mem[1],Mem[2],Mem[3]}; instr_valid one cycle after mem_ready.
- In HOLD with instr_ready=0 for 5 cycles, then 1 -> instr stable 5 cycles, mem_req=0 throughout; count increments once.
- redirect to 0x2C during FETCH of 0x08 with mem_ready 2 cycles later -> word from 0x08 never valid; next mem_addr=0x2C; instr_pc=0x2C.
- redirect to 0x31 while in HOLD, with accept in the same cycle -> pc=0x30, addr_err=1 sticky; count includes the accepted instruction.
- Reset asserted in FETCH with mem_req high -> immediate mem_req=0, instr_valid=0, count=0; after release the first mem_addr is RESET_PC.
